// File: rtl/program_memory.sv
// program_memory: DEPTH x 8 instruction store for the 8-bit processor.
// Reads are combinational. In load mode a debounced push button writes one
// switch byte per press at an auto-incrementing, saturating pointer, and the
// processor is held in reset through cpu_hold.
module program_memory #(
  parameter int          DEPTH           = 256,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter logic [7:0]  NOP_WORD        = 8'hC0
) (
  input  logic       oscillator,
  input  logic       reset,
  input  logic       load_mode,
  input  logic       load_strobe,
  input  logic [7:0] load_data,
  input  logic [7:0] instruction_address,
  output logic [7:0] instruction,
  output logic       cpu_hold,
  output logic [7:0] load_address,
  output logic       load_full,
  output logic       overflow,
  output logic [7:0] echo
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [8:0]      DEPTH_P  = 9'(DEPTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, WRITE, RELEASE} state_e;

  logic          mode_meta_q, mode_s_q, strobe_meta_q, strobe_s_q;
  logic          cpu_hold_q, cpu_hold_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    ptr_q, ptr_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    echo_q, echo_d;
  logic          wr_en;
  logic          mode_rise;
  logic          full;

  // Program store; powers up zeroed and is never touched by reset.
  logic [7:0] mem_q [2**AW] = '{default: 8'h00};

  assign full      = (ptr_q == DEPTH_P);
  assign mode_rise = mode_s_q & ~cpu_hold_q;

  // Two-flop synchronizers for the asynchronous switch and button.
  always_ff @(posedge oscillator or negedge reset) begin
    if (!reset) begin
      mode_meta_q   <= 1'b0;
      mode_s_q      <= 1'b0;
      strobe_meta_q <= 1'b0;
      strobe_s_q    <= 1'b0;
    end else begin
      mode_meta_q   <= load_mode;
      mode_s_q      <= mode_meta_q;
      strobe_meta_q <= load_strobe;
      strobe_s_q    <= strobe_meta_q;
    end
  end

  // Debounce FSM, write pointer and status next-state; a mode rise overrides all.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    ovf_d      = ovf_q;
    echo_d     = echo_q;
    wr_en      = 1'b0;
    cpu_hold_d = mode_s_q;
    case (state_q)
      IDLE: begin
        if (strobe_s_q) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (!strobe_s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (mode_s_q) begin
          if (!full) begin
            wr_en  = 1'b1;
            echo_d = load_data;
            ptr_d  = ptr_q + 9'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: begin
        if (strobe_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Entering load mode restarts the session; a coincident write is dropped.
    if (mode_rise) begin
      ptr_d   = '0;
      ovf_d   = 1'b0;
      echo_d  = '0;
      state_d = IDLE;
      cnt_d   = '0;
      wr_en   = 1'b0;
    end
  end

  // Control and status registers.
  always_ff @(posedge oscillator or negedge reset) begin
    if (!reset) begin
      cpu_hold_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      ovf_q      <= 1'b0;
      echo_q     <= '0;
    end else begin
      cpu_hold_q <= cpu_hold_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      ovf_q      <= ovf_d;
      echo_q     <= echo_d;
    end
  end

  // Store write port; ptr is below DEPTH whenever wr_en is set.
  always_ff @(posedge oscillator) begin
    if (wr_en) mem_q[ptr_q[AW-1:0]] <= load_data;
  end

  // Combinational read port with NOP for out-of-range fetches.
  always_comb begin
    instruction = NOP_WORD;
    if ({1'b0, instruction_address} < DEPTH_P)
      instruction = mem_q[instruction_address[AW-1:0]];
  end

  assign cpu_hold     = cpu_hold_q;
  assign load_address = ptr_q[7:0];
  assign load_full    = full;
  assign overflow     = ovf_q;
  assign echo         = echo_q;

endmodule

// File: tb/tb_program_memory.sv
// Scoreboard bench for program_memory (DEPTH=4, DEBOUNCE_CYCLES=4).
// Stimulus pushes expected writes and static checks into queues; a monitor
// on the falling edge pops and compares them against the DUT.
module tb_program_memory;

  logic       oscillator = 1'b0;
  logic       reset      = 1'b0;
  logic       load_mode  = 1'b1;
  logic       load_strobe = 1'b0;
  logic [7:0] load_data  = 8'h00;
  logic [7:0] instruction_address = 8'h00;
  logic [7:0] instruction;
  logic       cpu_hold;
  logic [7:0] load_address;
  logic       load_full;
  logic       overflow;
  logic [7:0] echo;

  program_memory #(.DEPTH(4), .DEBOUNCE_CYCLES(4), .NOP_WORD(8'hC0)) dut (
    .oscillator          (oscillator),
    .reset               (reset),
    .load_mode           (load_mode),
    .load_strobe         (load_strobe),
    .load_data           (load_data),
    .instruction_address (instruction_address),
    .instruction         (instruction),
    .cpu_hold            (cpu_hold),
    .load_address        (load_address),
    .load_full           (load_full),
    .overflow            (overflow),
    .echo                (echo)
  );

  always #5 oscillator = ~oscillator;

  int cyc = 0;
  always @(posedge oscillator) cyc++;

  typedef struct { string name; int sel; logic [31:0] exp; } chk_t;
  typedef struct { logic [7:0] data; logic [7:0] addr; int at; } wr_t;
  chk_t chk_q[$];
  wr_t  wr_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic [7:0] prev_addr = 8'h00;

  localparam int S_INSTR = 0, S_ADDR = 1, S_FULL = 2, S_OVF = 3, S_ECHO = 4, S_HOLD = 5;

  function automatic logic [31:0] pick(int sel);
    case (sel)
      S_INSTR: return {24'd0, instruction};
      S_ADDR:  return {24'd0, load_address};
      S_FULL:  return {31'd0, load_full};
      S_OVF:   return {31'd0, overflow};
      S_ECHO:  return {24'd0, echo};
      default: return {31'd0, cpu_hold};
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: drains static checks and matches every pointer step to an expected write.
  always @(negedge oscillator) begin
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      cmp(c.name, pick(c.sel), c.exp);
    end
    if (reset && load_address == prev_addr + 8'd1) begin
      if (wr_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected write: load_address %0h, echo %0h, none expected", load_address, echo);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        cmp("write echo", {24'd0, echo}, {24'd0, w.data});
        cmp("write pointer", {24'd0, load_address}, {24'd0, w.addr + 8'd1});
        if (w.at >= 0) cmp("write latency", cyc, w.at);
      end
    end
    prev_addr = load_address;
  end

  task automatic settle();
    int t = 0;
    while (chk_q.size() > 0 && t < 10) begin
      @(negedge oscillator); #1;
      t++;
    end
    if (chk_q.size() > 0) begin
      n_total++;
      $display("FAIL check drain timeout: %0d pending, 0 expected", chk_q.size());
      chk_q.delete();
    end
  endtask

  task automatic check(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.sel = sel; c.exp = exp;
    chk_q.push_back(c);
    settle();
  endtask

  task automatic check_instr(input logic [7:0] a, input logic [7:0] exp);
    @(posedge oscillator); #1;
    instruction_address = a;
    check($sformatf("instr@%0h", a), S_INSTR, {24'd0, exp});
  endtask

  task automatic wait_writes();
    int t = 0;
    while (wr_q.size() > 0 && t < 40) begin
      @(posedge oscillator);
      t++;
    end
    if (wr_q.size() > 0) begin
      n_total++;
      $display("FAIL missing write: %0d outstanding, 0 expected", wr_q.size());
      wr_q.delete();
    end
  endtask

  // One button press; expect_w queues the write the scoreboard must observe.
  task automatic press(input logic [7:0] d, input bit bouncy, input int hold,
                       input bit expect_w, input logic [7:0] addr);
    wr_t w;
    @(posedge oscillator); #1;
    load_data = d;
    load_strobe = 1'b1;
    w.data = d; w.addr = addr;
    w.at = bouncy ? -1 : cyc + 8;
    if (expect_w) wr_q.push_back(w);
    if (bouncy) begin
      repeat (2) @(posedge oscillator); #1;
      load_strobe = 1'b0;
      @(posedge oscillator); #1;
      load_strobe = 1'b1;
    end
    repeat (hold) @(posedge oscillator); #1;
    load_strobe = 1'b0;
    repeat (12) @(posedge oscillator);
    wait_writes();
  endtask

  task automatic set_mode(input logic m);
    @(posedge oscillator); #1;
    load_mode = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, finish expected earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge oscillator); #1;
    reset = 1'b1;
    // Reset state and power-up contents
    check("reset cpu_hold", S_HOLD, 1);
    check("reset load_address", S_ADDR, 0);
    check("reset load_full", S_FULL, 0);
    check("reset overflow", S_OVF, 0);
    check("reset echo", S_ECHO, 0);
    check_instr(8'h00, 8'h00);
    check_instr(8'h04, 8'hC0);
    repeat (5) @(posedge oscillator);

    // Clean, bouncy and clean presses load three bytes
    press(8'h1D, 1'b0, 10, 1'b1, 8'h00);
    check("after clean echo", S_ECHO, 32'h1D);
    check("after clean load_address", S_ADDR, 1);
    press(8'h45, 1'b1, 50, 1'b1, 8'h01);
    check("after bouncy load_address", S_ADDR, 2);
    press(8'hC0, 1'b0, 10, 1'b1, 8'h02);

    // Leaving load mode: cpu_hold falls on the third edge
    set_mode(1'b0);
    repeat (2) @(posedge oscillator);
    check("cpu_hold edge 2", S_HOLD, 1);
    @(posedge oscillator);
    check("cpu_hold edge 3", S_HOLD, 0);
    check_instr(8'h00, 8'h1D);
    check_instr(8'h01, 8'h45);
    check_instr(8'h02, 8'hC0);
    check_instr(8'h03, 8'h00);

    // Press in run mode has no effect
    press(8'h99, 1'b0, 10, 1'b0, 8'h00);
    check("run press load_address", S_ADDR, 3);
    check("run press echo", S_ECHO, 32'hC0);
    check_instr(8'h03, 8'h00);

    // Re-entering load mode clears pointer on the third edge
    set_mode(1'b1);
    repeat (2) @(posedge oscillator);
    check("mode rise edge 2 ptr", S_ADDR, 3);
    @(posedge oscillator);
    check("mode rise edge 3 ptr", S_ADDR, 0);
    check("mode rise cpu_hold", S_HOLD, 1);
    check("mode rise echo", S_ECHO, 0);
    check_instr(8'h01, 8'h45);

    // Fill to DEPTH then overflow
    press(8'h11, 1'b0, 10, 1'b1, 8'h00);
    press(8'h22, 1'b0, 10, 1'b1, 8'h01);
    press(8'h33, 1'b0, 10, 1'b1, 8'h02);
    check("pre-full load_full", S_FULL, 0);
    press(8'h44, 1'b0, 10, 1'b1, 8'h03);
    check("full load_full", S_FULL, 1);
    check("full load_address", S_ADDR, 4);
    check("full overflow", S_OVF, 0);
    press(8'h55, 1'b0, 10, 1'b0, 8'h00);
    check("overflow sticky", S_OVF, 1);
    check("overflow echo", S_ECHO, 32'h44);
    check_instr(8'h00, 8'h11);
    check_instr(8'h01, 8'h22);
    check_instr(8'h02, 8'h33);
    check_instr(8'h03, 8'h44);
    check_instr(8'h04, 8'hC0);
    check_instr(8'hFF, 8'hC0);

    // Mode toggle clears status, keeps contents; new press overwrites mem[0]
    set_mode(1'b0);
    repeat (6) @(posedge oscillator);
    set_mode(1'b1);
    repeat (6) @(posedge oscillator);
    check("toggle overflow", S_OVF, 0);
    check("toggle load_full", S_FULL, 0);
    check("toggle echo", S_ECHO, 0);
    check("toggle load_address", S_ADDR, 0);
    check_instr(8'h00, 8'h11);
    press(8'hAA, 1'b0, 10, 1'b1, 8'h00);
    check_instr(8'h00, 8'hAA);
    check_instr(8'h01, 8'h22);

    // Reset while in ARM drops the write and keeps the store
    @(posedge oscillator); #1;
    load_data = 8'h77;
    load_strobe = 1'b1;
    repeat (5) @(posedge oscillator); #1;
    reset = 1'b0;
    load_strobe = 1'b0;
    check("arm reset load_address", S_ADDR, 0);
    check("arm reset echo", S_ECHO, 0);
    check("arm reset cpu_hold", S_HOLD, 1);
    check("arm reset overflow", S_OVF, 0);
    repeat (3) @(posedge oscillator); #1;
    reset = 1'b1;
    repeat (12) @(posedge oscillator);
    check("post reset load_address", S_ADDR, 0);
    check_instr(8'h00, 8'hAA);
    check_instr(8'h01, 8'h22);
    check_instr(8'h03, 8'h44);

    repeat (4) @(posedge oscillator);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
